fetch_unit: RTL and testbench

Instruction fetch and issue stage that produces the `opcode`/`funct` stream consumed by the main/ALU decoders and acts on the `PcSrc`/`Jump` decisions those decoders return. It owns the program counter, issues word reads to instruction memory over a ready-qualified request interface, and buffers returned words in a small prefetch FIFO. It presents one instruction at a time to the decode/execute side under a valid/ready handshake. A taken branch or jump flushes the FIFO and restarts fetch at the target.

---
 rtl/fetch_if.sv | 25 ++
 rtl/fetch_unit.sv | 72 +++++++
 tb/tb_fetch_unit.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory request and instruction-issue signals between the fetch stage and its neighbours.
interface fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] pc_plus4;
  logic        PcSrc;
  logic        Jump;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  modport master (
    output imem_req, imem_addr, instr_valid, instr, opcode, funct, pc_plus4,
    input  imem_ready, imem_rdata, instr_ready, PcSrc, Jump, branch_target, jump_target
  );
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, opcode, funct, pc_plus4,
    output imem_ready, imem_rdata, instr_ready, PcSrc, Jump, branch_target, jump_target
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, prefetch FIFO and redirect handling for the decode stage.
// Define FETCH_BYPASS_EN to forward a word fetched into an empty FIFO straight to the head.
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic     clk,
  input  logic     reset,
  fetch_if.master  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {FETCH, FLUSH} state_e;
  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [31:0]     word_q [DEPTH];
  logic [31:0]     addr_q [DEPTH];
  logic            empty, push, pop, byp, redirect, wr_en, rd_en;
  logic [31:0]     head_word, head_addr, target;
  always_comb begin
    empty         = cnt_q == '0;
    bus.imem_req  = state_q == FETCH && cnt_q != CW'(DEPTH);
    bus.imem_addr = pc_q;
    push          = bus.imem_req && bus.imem_ready;
`ifdef FETCH_BYPASS_EN
    byp           = push && empty;
`else
    byp           = 1'b0;
`endif
    bus.instr_valid = !empty || byp;
    head_word     = byp ? bus.imem_rdata : empty ? '0 : word_q[rd_q];
    head_addr     = byp ? pc_q : empty ? '0 : addr_q[rd_q];
    bus.instr     = head_word;
    bus.opcode    = head_word[31:26];
    bus.funct     = head_word[5:0];
    bus.pc_plus4  = bus.instr_valid ? head_addr + 32'd4 : '0;
    pop           = bus.instr_valid && bus.instr_ready;
    redirect      = pop && (bus.Jump || bus.PcSrc);
    target        = (bus.Jump ? bus.jump_target : bus.branch_target) & ~32'd3;
    // a bypassed word that is consumed at once never touches the storage
    wr_en         = push && !redirect && !(byp && pop);
    rd_en         = pop && !byp;
    cnt_d         = redirect ? '0 : cnt_q + CW'(wr_en) - CW'(rd_en);
    wr_d          = redirect ? '0 : wr_q + AW'(wr_en);
    rd_d          = redirect ? '0 : rd_q + AW'(rd_en);
    pc_d          = redirect ? target : push ? pc_q + 32'd4 : pc_q;
    state_d       = redirect ? FLUSH : FETCH;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      word_q[wr_q] <= bus.imem_rdata;
      addr_q[wr_q] <= pc_q;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus a randomized run against a queue-based fetch model.
module tb_fetch_unit;
  localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 0;
  localparam bit BYP = 1'b1;
`else
  localparam int LAT = 1;
  localparam bit BYP = 1'b0;
`endif
  logic clk;
  logic reset;
  int   checks;
  int   failures;
  fetch_if bus ();
  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (.clk(clk), .reset(reset), .bus(bus.master));
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
  endfunction
  assign bus.imem_rdata = word_of(bus.imem_addr);
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic apply_reset();
    reset = 1'b1;
    bus.imem_ready = 1'b0;
    bus.instr_ready = 1'b0;
    bus.PcSrc = 1'b0;
    bus.Jump = 1'b0;
    step();
    reset = 1'b0;
  endtask
  task automatic test_reset();
    apply_reset();
    #1;
    checks += 5;
    if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", bus.instr_valid); end
    if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL reset_req got=%0b exp=1", bus.imem_req); end
    if (bus.imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", bus.imem_addr); end
    if (bus.instr !== 32'h0 || bus.opcode !== 6'h0 || bus.funct !== 6'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", bus.instr); end
    if (bus.pc_plus4 !== 32'h0) begin failures++; $display("FAIL reset_pc4 got=%h exp=0", bus.pc_plus4); end
  endtask
  task automatic test_stream();
    logic [31:0] a;
    apply_reset();
    bus.imem_ready = 1'b1;
    bus.instr_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      checks++;
      if (bus.instr_valid !== (k >= LAT)) begin failures++; $display("FAIL stream_valid k=%0d got=%0b exp=%0b", k, bus.instr_valid, k >= LAT); end
      if (k >= LAT) begin
        a = 32'(4 * (k - LAT));
        checks += 2;
        if (bus.pc_plus4 !== a + 32'd4) begin failures++; $display("FAIL stream_pc4 k=%0d got=%h exp=%h", k, bus.pc_plus4, a + 32'd4); end
        if (bus.instr !== word_of(a)) begin failures++; $display("FAIL stream_instr k=%0d got=%h exp=%h", k, bus.instr, word_of(a)); end
      end
      step();
    end
  endtask
  task automatic test_full();
    int acc;
    acc = 0;
    apply_reset();
    bus.imem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus.imem_req) acc++;
      step();
    end
    checks += 2;
    if (acc != DEPTH) begin failures++; $display("FAIL full_accepts got=%0d exp=%0d", acc, DEPTH); end
    bus.instr_ready = 1'b1;
    #1;
    if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL full_req_on_pop got=%0b exp=0", bus.imem_req); end
    checks++;
    if (bus.pc_plus4 !== 32'h4) begin failures++; $display("FAIL full_head got=%h exp=4", bus.pc_plus4); end
    step();
    bus.instr_ready = 1'b0;
    #1;
    checks += 2;
    if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL full_req_back got=%0b exp=1", bus.imem_req); end
    if (bus.imem_addr !== 32'h10) begin failures++; $display("FAIL full_addr got=%h exp=10", bus.imem_addr); end
  endtask
  task automatic test_branch();
    bit found, seen;
    int bad;
    logic [31:0] first, a;
    found = 0; seen = 0; bad = 0; first = '0;
    apply_reset();
    bus.imem_ready = 1'b1;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      #1;
      if (bus.instr_valid && bus.pc_plus4 == 32'hC) begin
        bus.PcSrc = 1'b1;
        bus.branch_target = 32'h40;
        found = 1;
      end
      step();
    end
    checks++;
    if (!found) begin failures++; $display("FAIL branch_head_timeout got=none exp=8"); end
    bus.PcSrc = 1'b0;
    #1;
    checks += 2;
    if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL branch_bubble_req got=%0b exp=0", bus.imem_req); end
    if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL branch_bubble_valid got=%0b exp=0", bus.instr_valid); end
    step();
    #1;
    checks += 2;
    if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL branch_req got=%0b exp=1", bus.imem_req); end
    if (bus.imem_addr !== 32'h40) begin failures++; $display("FAIL branch_addr got=%h exp=40", bus.imem_addr); end
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin step(); #1; end
      if (bus.instr_valid) begin
        a = bus.pc_plus4 - 32'd4;
        if (!seen) begin first = a; seen = 1; end
        if (a >= 32'hC && a <= 32'h18) bad++;
      end
    end
    checks += 2;
    if (bad != 0) begin failures++; $display("FAIL branch_stale_issue got=%0d exp=0", bad); end
    if (first !== 32'h40) begin failures++; $display("FAIL branch_first got=%h exp=40", first); end
  endtask
  task automatic test_jump();
    bit found;
    found = 0;
    apply_reset();
    bus.imem_ready = 1'b1;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      #1;
      if (bus.instr_valid && bus.pc_plus4 == 32'h8) begin
        bus.Jump = 1'b1;
        bus.PcSrc = 1'b1;
        bus.jump_target = 32'h103;
        bus.branch_target = 32'h80;
        found = 1;
      end
      step();
    end
    checks++;
    if (!found) begin failures++; $display("FAIL jump_head_timeout got=none exp=4"); end
    bus.Jump = 1'b0;
    bus.PcSrc = 1'b0;
    #1;
    checks++;
    if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL jump_bubble_req got=%0b exp=0", bus.imem_req); end
    step();
    #1;
    checks++;
    if (bus.imem_addr !== 32'h100 || bus.imem_req !== 1'b1) begin failures++; $display("FAIL jump_addr got=%h req=%0b exp=100", bus.imem_addr, bus.imem_req); end
  endtask
  task automatic test_stall();
    int pat [7] = '{1, 0, 0, 1, 0, 1, 0};
    logic [31:0] exp_pc;
    exp_pc = '0;
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      bus.imem_ready = pat[i][0];
      #1;
      checks += 2;
      if (bus.imem_addr !== exp_pc) begin failures++; $display("FAIL stall_addr i=%0d got=%h exp=%h", i, bus.imem_addr, exp_pc); end
      if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL stall_req i=%0d got=%0b exp=1", i, bus.imem_req); end
      if (pat[i] == 1) exp_pc += 32'd4;
      step();
    end
    bus.imem_ready = 1'b0;
    bus.instr_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #1;
      checks += 2;
      if (bus.instr_valid !== 1'b1 || bus.pc_plus4 !== 32'(4 * j + 4)) begin failures++; $display("FAIL stall_order j=%0d got=%h exp=%h", j, bus.pc_plus4, 32'(4 * j + 4)); end
      if (bus.instr !== word_of(32'(4 * j))) begin failures++; $display("FAIL stall_word j=%0d got=%h exp=%h", j, bus.instr, word_of(32'(4 * j))); end
      step();
    end
    #1;
    checks++;
    if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL stall_drained got=%0b exp=0", bus.instr_valid); end
  endtask
  task automatic test_reset_mid();
    apply_reset();
    bus.imem_ready = 1'b1;
    step();
    step();
    step();
    reset = 1'b1;
    bus.instr_ready = 1'b1;
    bus.PcSrc = 1'b1;
    bus.branch_target = 32'h40;
    step();
    reset = 1'b0;
    bus.imem_ready = 1'b0;
    bus.instr_ready = 1'b0;
    bus.PcSrc = 1'b0;
    #1;
    checks += 3;
    if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%0b exp=0", bus.instr_valid); end
    if (bus.imem_addr !== 32'h0) begin failures++; $display("FAIL rstmid_addr got=%h exp=0", bus.imem_addr); end
    if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL rstmid_req got=%0b exp=1", bus.imem_req); end
  endtask
  task automatic test_random();
    logic [31:0] q [$];
    logic [31:0] pc_m, head, e_instr, e_pp4;
    bit bubble, e_req, push, byp, e_valid, pop, redir;
    apply_reset();
    pc_m = '0;
    bubble = 0;
    for (int n = 0; n < 3000; n++) begin
      bus.imem_ready = $urandom_range(0, 9) < 7;
      bus.instr_ready = $urandom_range(0, 9) < 6;
      bus.PcSrc = $urandom_range(0, 9) == 0;
      bus.Jump = $urandom_range(0, 15) == 0;
      bus.branch_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      bus.jump_target = $urandom;
      #1;
      e_req = !bubble && q.size() < DEPTH;
      push = e_req && bus.imem_ready;
      byp = BYP && push && q.size() == 0;
      e_valid = q.size() > 0 || byp;
      head = (q.size() > 0) ? q[0] : pc_m;
      e_instr = e_valid ? word_of(head) : 32'h0;
      e_pp4 = e_valid ? head + 32'd4 : 32'h0;
      checks += 7;
      if (bus.imem_req !== e_req) begin failures++; $display("FAIL rnd_req n=%0d got=%0b exp=%0b", n, bus.imem_req, e_req); end
      if (bus.imem_addr !== pc_m) begin failures++; $display("FAIL rnd_addr n=%0d got=%h exp=%h", n, bus.imem_addr, pc_m); end
      if (bus.instr_valid !== e_valid) begin failures++; $display("FAIL rnd_valid n=%0d got=%0b exp=%0b", n, bus.instr_valid, e_valid); end
      if (bus.instr !== e_instr) begin failures++; $display("FAIL rnd_instr n=%0d got=%h exp=%h", n, bus.instr, e_instr); end
      if (bus.opcode !== e_instr[31:26]) begin failures++; $display("FAIL rnd_opcode n=%0d got=%h exp=%h", n, bus.opcode, e_instr[31:26]); end
      if (bus.funct !== e_instr[5:0]) begin failures++; $display("FAIL rnd_funct n=%0d got=%h exp=%h", n, bus.funct, e_instr[5:0]); end
      if (bus.pc_plus4 !== e_pp4) begin failures++; $display("FAIL rnd_pc4 n=%0d got=%h exp=%h", n, bus.pc_plus4, e_pp4); end
      pop = e_valid && bus.instr_ready;
      redir = pop && (bus.Jump || bus.PcSrc);
      if (redir) begin
        q.delete();
        pc_m = (bus.Jump ? bus.jump_target : bus.branch_target) & 32'hFFFF_FFFC;
        bubble = 1;
      end else begin
        bubble = 0;
        if (pop && !byp) void'(q.pop_front());
        if (push && !(byp && pop)) q.push_back(pc_m);
        if (push) pc_m = pc_m + 32'd4;
      end
      step();
    end
  endtask
  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus.imem_ready = 1'b0;
    bus.instr_ready = 1'b0;
    bus.PcSrc = 1'b0;
    bus.Jump = 1'b0;
    bus.branch_target = '0;
    bus.jump_target = '0;
    test_reset();
    test_stream();
    test_full();
    test_branch();
    test_jump();
    test_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
